// File: rtl/vga_scan_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared timing defaults, coordinate types and total-count
//                helpers for the VGA scan generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Coordinate width; both totals must fit in this many bits
    localparam int COORD_W     = 10;
    localparam int c_coord_max = 1 << COORD_W;

    // 640x480 @ 60 Hz timing defaults
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    typedef logic [COORD_W-1:0] coord_t;
    // One bit wider than a coordinate so boundaries equal to 1024 still fit
    typedef logic [COORD_W:0]   coord_ext_t;

    // Pixels per line including all blanking
    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame including all blanking
    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scan_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen_if
//  Description : Scan-timing bundle from the VGA scan generator to the
//                drawing pipeline. frame_cnt exists only when
//                VGA_SCAN_FRAME_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_scan_gen_if;
    import vga_pkg::*;

    coord_t     Q_X;
    coord_t     Q_Y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_tick;
    logic       line_start;
    logic       frame_start;
`ifdef VGA_SCAN_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

`ifdef VGA_SCAN_FRAME_CNT_EN
    modport master (
        output Q_X, Q_Y, hsync, vsync, video_on,
        output pix_tick, line_start, frame_start, frame_cnt
    );
    modport slave (
        input  Q_X, Q_Y, hsync, vsync, video_on,
        input  pix_tick, line_start, frame_start, frame_cnt
    );
`else
    modport master (
        output Q_X, Q_Y, hsync, vsync, video_on,
        output pix_tick, line_start, frame_start
    );
    modport slave (
        input  Q_X, Q_Y, hsync, vsync, video_on,
        input  pix_tick, line_start, frame_start
    );
`endif

endinterface
`default_nettype wire

// File: rtl/vga_scan_gen_pix_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pix_tick_gen
//  Description : Divides the system clock into a one-clock pixel strobe.
//                The divider counts 0..CLK_DIV-1 and the strobe is high in
//                the cycle where it holds CLK_DIV-1. With CLK_DIV=1 the
//                strobe is permanently high.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam int                 c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_div_check
        $error("pix_tick_gen: CLK_DIV must be at least 1");
    end

    logic [c_div_w-1:0] r_div;
    logic [c_div_w-1:0] w_div_next;
    logic               r_tick;

    // Next divider phase, wrapping after CLK_DIV-1
    always_comb begin
        w_div_next = r_div + c_div_w'(1);
        if (r_div == c_div_last) begin
            w_div_next = '0;
        end
    end

    // Divider phase and the strobe, registered from the next phase so the
    // strobe is a clean flop output aligned with the divider value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= (CLK_DIV == 1);
        end else begin
            r_div  <= w_div_next;
            r_tick <= (w_div_next == c_div_last);
        end
    end

    assign pix_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen
//  Description : VGA raster timing generator. Runs horizontal/vertical scan
//                counters on the pixel strobe and produces registered sync,
//                blanking and line/frame strobes aligned with Q_X/Q_Y.
//                Optional macro VGA_SCAN_FRAME_CNT_EN adds an 8-bit frame
//                counter output on the interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_scan_gen_if.master scan
);

    localparam int c_h_total = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (c_h_total > c_coord_max) begin : g_h_total_check
        $error("vga_scan_gen: horizontal total exceeds coordinate range");
    end
    if (c_v_total > c_coord_max) begin : g_v_total_check
        $error("vga_scan_gen: vertical total exceeds coordinate range");
    end

    localparam coord_t     c_h_last       = coord_t'(c_h_total - 1);
    localparam coord_t     c_v_last       = coord_t'(c_v_total - 1);
    localparam coord_ext_t c_h_active_e   = coord_ext_t'(H_ACTIVE);
    localparam coord_ext_t c_v_active_e   = coord_ext_t'(V_ACTIVE);
    localparam coord_ext_t c_h_sync_start = coord_ext_t'(H_ACTIVE + H_FP);
    localparam coord_ext_t c_h_sync_end   = coord_ext_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_ext_t c_v_sync_start = coord_ext_t'(V_ACTIVE + V_FP);
    localparam coord_ext_t c_v_sync_end   = coord_ext_t'(V_ACTIVE + V_FP + V_SYNC);

    logic       w_tick;
    coord_t     r_qx;
    coord_t     r_qy;
    coord_t     w_qx_next;
    coord_t     w_qy_next;
    logic       w_line_wrap;
    logic       w_frame_wrap;
    coord_ext_t w_qx_ext;
    coord_ext_t w_qy_ext;
    logic       w_hs_active;
    logic       w_vs_active;
    logic       w_video_next;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_line_start;
    logic       r_frame_start;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (w_tick)
    );

    // Next scan position: advance one pixel per tick, wrapping line and frame
    always_comb begin
        w_qx_next    = r_qx;
        w_qy_next    = r_qy;
        w_line_wrap  = 1'b0;
        w_frame_wrap = 1'b0;
        if (w_tick) begin
            if (r_qx == c_h_last) begin
                w_qx_next   = '0;
                w_line_wrap = 1'b1;
                if (r_qy == c_v_last) begin
                    w_qy_next    = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_qy_next = r_qy + coord_t'(1);
                end
            end else begin
                w_qx_next = r_qx + coord_t'(1);
            end
        end
    end

    // Sync and blanking decoded from the next position so the registered
    // versions change on the same edge as the counters
    always_comb begin
        w_qx_ext     = coord_ext_t'(w_qx_next);
        w_qy_ext     = coord_ext_t'(w_qy_next);
        w_hs_active  = (w_qx_ext >= c_h_sync_start) && (w_qx_ext < c_h_sync_end);
        w_vs_active  = (w_qy_ext >= c_v_sync_start) && (w_qy_ext < c_v_sync_end);
        w_video_next = (w_qx_ext < c_h_active_e) && (w_qy_ext < c_v_active_e);
    end

    // Scan counters, registered decode and strobes; reset parks the scan on
    // the last pixel of the frame so the first tick lands on (0,0)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_qx          <= c_h_last;
            r_qy          <= c_v_last;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_qx          <= w_qx_next;
            r_qy          <= w_qy_next;
            r_hsync       <= w_hs_active ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_active ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_video_next;
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_SCAN_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    // Frame counter for animation; steps on each frame-start cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (r_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign scan.frame_cnt = r_frame_cnt;
`endif

    assign scan.Q_X         = r_qx;
    assign scan.Q_Y         = r_qy;
    assign scan.hsync       = r_hsync;
    assign scan.vsync       = r_vsync;
    assign scan.video_on    = r_video_on;
    assign scan.pix_tick    = w_tick;
    assign scan.line_start  = r_line_start;
    assign scan.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Generates VGA raster timing and the scan coordinates Q_X/Q_Y consumed by the area/shape detectors that produce Aden-style enables.
- Divides the system clock into a pixel tick and runs horizontal and vertical counters.
- Outputs hsync, vsync, video_on, plus line and frame strobes for the drawing pipeline.

Parameters:
- CLK_DIV, 2, system clocks per pixel (≥1); 50 MHz in gives 25 MHz pixels.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- Q_X  out  10  current horizontal count, 0..H_TOTAL-1.
- Q_Y  out  10  current vertical count, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- video_on  out  1  high when Q_X<H_ACTIVE and Q_Y<V_ACTIVE.
- pix_tick  out  1  one-clk strobe; counters advance on the edge where it is high.
- line_start  out  1  one-clk pulse after Q_X wraps to 0.
- frame_start  out  1  one-clk pulse after (Q_X,Q_Y) wraps to (0,0).

Behaviour:
- One clock; reset is synchronous and active-low: rst_n sampled only on the rising edge of clk.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Elaboration error if either total exceeds 1024.
- Reset values:
  - Divider = 0.
  - Q_X = H_TOTAL-1, Q_Y = V_TOTAL-1, i.e. the last pixel of the frame, in back porch.
  - hsync = vsync = !SYNC_POL.
  - video_on, pix_tick, line_start, frame_start = 0.
  - Outputs are therefore self-consistent with the counter state from reset onward.
- Divider:
  - Counts 0..CLK_DIV-1.
  - pix_tick is high in the cycle where the divider equals CLK_DIV-1, then the divider wraps to 0.
  - CLK_DIV=1 gives pix_tick constantly high.
- Counters: on a clk edge with pix_tick=1:
  - If Q_X = H_TOTAL-1: Q_X ← 0. Then, if Q_Y = V_TOTAL-1, Q_Y ← 0; otherwise Q_Y ← Q_Y+1.
  - Otherwise: Q_X ← Q_X+1.
  - Without pix_tick, all counters hold.
- Sync and blanking:
  - hsync, vsync and video_on are registered, decoded from the next-state counters, so they change on the same edge as Q_X/Q_Y. No combinational glitches at the ports.
  - hsync = SYNC_POL when H_ACTIVE+H_FP ≤ Q_X < H_ACTIVE+H_FP+H_SYNC.
  - vsync = SYNC_POL when V_ACTIVE+V_FP ≤ Q_Y < V_ACTIVE+V_FP+V_SYNC.
- Strobes:
  - line_start is high for exactly one clk in the cycle whose Q_X first shows 0.
  - frame_start is high for exactly one clk when Q_X=0 and Q_Y=0; line_start is also high in that cycle.
- Latency: first frame_start occurs CLK_DIV clocks after rst_n deasserts.
- Reset mid-frame: next edge with rst_n=0 forces the reset values regardless of divider phase; no partial strobes.
- Q_X/Q_Y are never gated by video_on; consumers AND their area enables with video_on.

Optional Feature:
- VGA_SCAN_FRAME_CNT_EN defined: adds output frame_cnt [7:0].
  - Reset 0.
  - Increments on every frame_start cycle; wraps 255→0.
  - Used for animation and blinking.
- Not defined: port and register are absent; all other behaviour identical.

Decomposition:
- Package vga_pkg:
  - Timing defaults: 640x480@60 constants.
  - Derived H_TOTAL/V_TOTAL functions.
  - COORD_W=10.
  - typedef logic [9:0] coord_t.
- One sub-module: pix_tick_gen (parameter CLK_DIV; clk, rst_n → pix_tick).
- Counters and decode stay in vga_scan_gen.

Test Plan:
- Reset release, defaults → Q_X=799, Q_Y=524, hsync=vsync=1, video_on=0; 2 clks later Q_X=0, Q_Y=0, frame_start=1, line_start=1, video_on=1.
- Run one line → hsync low exactly for Q_X 656..751 (96 ticks = 192 clks); video_on falls at Q_X=640; line period 1600 clks.
- Run one frame → vsync low for Q_Y 490..491; frame_start period 800×525×2 = 840000 clks; exactly one frame_start and 525 line_start pulses.
- Assert rst_n=0 at Q_X=300, Q_Y=200 for one clk → next cycle shows reset values; resumes from (0,0) with no extra strobe.
- CLK_DIV=1, SYNC_POL=1 → pix_tick constant 1; hsync high during Q_X 656..751; line period 800 clks.
- With VGA_SCAN_FRAME_CNT_EN, run 257 frames → frame_cnt sequence 0,1,…,255,0,1.
